// File: rtl/sdram_ex_pkg.sv
// Shared definitions for the SDRAM example traffic path: LFSR polynomial and
// checker state encoding, used by both the write generator and the read checker.
package sdram_ex_pkg;

  // XOR mask folded into bits 4:2 when the outgoing bit q7 is set
  localparam logic [7:0] LFSR8_TAPS = 8'b0001_1100;

  typedef logic [1:0] chk_state_t;

  localparam chk_state_t ST_IDLE  = 2'd0;
  localparam chk_state_t ST_CHECK = 2'd1;
  localparam chk_state_t ST_DONE  = 2'd2;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7]} ^ (q[7] ? LFSR8_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/sdram_ex_lfsr8_lane.sv
// One byte lane of the pattern regenerator: seedable 8-bit LFSR that reloads
// on reset or load and steps only when advance is asserted.
module sdram_ex_lfsr8_lane #(
  parameter logic [7:0] SEED = 8'h20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_advance,
  output logic [7:0] o_q
);
  import sdram_ex_pkg::*;

  logic [7:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_q <= SEED;
    end else if (i_advance) begin
      r_q <= lfsr8_next(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sdram_ex_lfsr_checker.sv
// Read-side checker: compares returned beats against the regenerated LFSR
// pattern, counts mismatching beats and captures the first failing beat.
//
// state | meaning
// IDLE  | after reset, waiting for start
// CHECK | comparing beats, busy high
// DONE  | run finished, pass/err_count held until next start
module sdram_ex_lfsr_checker #(
  parameter int NUM_LANES = 2,
  parameter int SEED      = 32,
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [CNT_W-1:0]       i_num_words,
  input  logic                   i_rd_valid,
  input  logic [8*NUM_LANES-1:0] i_rd_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [ERR_W-1:0]       o_err_count,
  output logic [CNT_W-1:0]       o_first_err_idx,
  output logic [8*NUM_LANES-1:0] o_first_err_data,
  output logic [8*NUM_LANES-1:0] o_first_err_exp
);
  import sdram_ex_pkg::*;

  localparam int DW = 8 * NUM_LANES;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_t       r_state;
  logic [CNT_W-1:0] r_num_words;
  logic [CNT_W-1:0] r_beat_idx;
  logic [ERR_W-1:0] r_err_count;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_first_idx;
  logic [DW-1:0]    r_first_data;
  logic [DW-1:0]    r_first_exp;

  logic [DW-1:0]    w_expected;
  logic             w_start_ok;
  logic             w_beat;
  logic             w_mismatch;
  logic             w_last;

  assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_beat     = (r_state == ST_CHECK) && i_rd_valid;
  assign w_mismatch = w_beat && (i_rd_data != w_expected);
  assign w_last     = (r_beat_idx == r_num_words - CNT_W'(1));

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sdram_ex_lfsr8_lane #(
      .SEED(8'((SEED + k) % 256))
    ) u_lane (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_start_ok),
      .i_advance (w_beat),
      .o_q       (w_expected[8*k +: 8])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_num_words  <= '0;
      r_beat_idx   <= '0;
      r_err_count  <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_first_idx  <= '0;
      r_first_data <= '0;
      r_first_exp  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_num_words  <= i_num_words;
        r_beat_idx   <= '0;
        r_err_count  <= '0;
        r_first_idx  <= '0;
        r_first_data <= '0;
        r_first_exp  <= '0;
        // An empty run completes immediately with a clean result
        if (i_num_words == '0) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          r_pass  <= 1'b1;
        end else begin
          r_state <= ST_CHECK;
          r_pass  <= 1'b0;
        end
      end else if (w_beat) begin
        r_beat_idx <= r_beat_idx + CNT_W'(1);
        if (w_mismatch) begin
          if (r_err_count != ERR_MAX) begin
            r_err_count <= r_err_count + ERR_W'(1);
          end
          if (r_err_count == '0) begin
            r_first_idx  <= r_beat_idx;
            r_first_data <= i_rd_data;
            r_first_exp  <= w_expected;
          end
        end
        if (w_last) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          r_pass  <= !w_mismatch && (r_err_count == '0);
        end
      end
    end
  end

  assign o_busy           = (r_state == ST_CHECK);
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_idx  = r_first_idx;
  assign o_first_err_data = r_first_data;
  assign o_first_err_exp  = r_first_exp;

endmodule

// File: tb/tb_sdram_ex_lfsr_checker.sv
// Bench for sdram_ex_lfsr_checker: a one-lane and a two-lane (3-bit error
// counter) instance, each tracked by a transaction-level model.
module tb_sdram_ex_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_start, a_valid, a_busy, a_done, a_pass;
  logic [15:0] a_nw, a_err, a_fidx;
  logic [7:0]  a_data, a_fdata, a_fexp;

  logic        b_start, b_valid, b_busy, b_done, b_pass;
  logic [15:0] b_nw, b_fidx, b_data, b_fdata, b_fexp;
  logic [2:0]  b_err;

  sdram_ex_lfsr_checker #(.NUM_LANES(1), .SEED(32), .CNT_W(16), .ERR_W(16)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(a_start), .i_num_words(a_nw),
    .i_rd_valid(a_valid), .i_rd_data(a_data), .o_busy(a_busy), .o_done(a_done),
    .o_pass(a_pass), .o_err_count(a_err), .o_first_err_idx(a_fidx),
    .o_first_err_data(a_fdata), .o_first_err_exp(a_fexp));

  sdram_ex_lfsr_checker #(.NUM_LANES(2), .SEED(32), .CNT_W(16), .ERR_W(3)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(b_start), .i_num_words(b_nw),
    .i_rd_valid(b_valid), .i_rd_data(b_data), .o_busy(b_busy), .o_done(b_done),
    .o_pass(b_pass), .o_err_count(b_err), .o_first_err_idx(b_fidx),
    .o_first_err_data(b_fdata), .o_first_err_exp(b_fexp));

  typedef struct {
    bit          run;
    int          words;
    int          idx;
    int          errs;
    int          fidx;
    logic [15:0] fdata;
    logic [15:0] fexp;
    bit          pass;
    bit          done;
  } mdl_t;

  mdl_t m[2];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  // Pattern as repeated multiplication by x in GF(2^8) mod x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] mul_x(input logic [7:0] v);
    int t;
    t = int'(v) * 2;
    if (t >= 256) t = t ^ 'h11D;
    return 8'(t);
  endfunction

  function automatic logic [15:0] expected(input int lanes, input int n);
    logic [15:0] r;
    logic [7:0]  v;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      v = 8'(32 + k);
      for (int i = 0; i < n; i++) v = mul_x(v);
      r[8*k +: 8] = v;
    end
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t s, input int lanes, input int sat, input bit rst,
                                input bit st, input int nw, input bit v, input logic [15:0] d);
    mdl_t        o;
    logic [15:0] e;
    o = s;
    o.done = 1'b0;
    if (rst) begin
      o = '{default: 0};
    end else if (st && !o.run) begin
      o.words = nw; o.idx = 0; o.errs = 0; o.fidx = 0; o.fdata = '0; o.fexp = '0;
      if (nw == 0) begin o.done = 1'b1; o.pass = 1'b1; end
      else begin o.run = 1'b1; o.pass = 1'b0; end
    end else if (o.run && v) begin
      e = expected(lanes, o.idx);
      if (d != e) begin
        if (o.errs == 0) begin o.fidx = o.idx; o.fdata = d; o.fexp = e; end
        if (o.errs < sat) o.errs = o.errs + 1;
      end
      o.idx = o.idx + 1;
      if (o.idx == o.words) begin o.run = 1'b0; o.done = 1'b1; o.pass = (o.errs == 0); end
    end
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    m[0] <= step(m[0], 1, 65535, reset, a_start, int'(a_nw), a_valid, {8'h00, a_data});
    m[1] <= step(m[1], 2, 7, reset, b_start, int'(b_nw), b_valid, b_data);
    if (reset) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_busy",  {31'd0, a_busy}, {31'd0, m[0].run});
      check("a_done",  {31'd0, a_done}, {31'd0, m[0].done});
      check("a_pass",  {31'd0, a_pass}, {31'd0, m[0].pass});
      check("a_err",   {16'd0, a_err},  m[0].errs);
      check("a_fidx",  {16'd0, a_fidx}, m[0].fidx);
      check("a_fdata", {24'd0, a_fdata}, {16'd0, m[0].fdata});
      check("a_fexp",  {24'd0, a_fexp},  {16'd0, m[0].fexp});
      check("b_busy",  {31'd0, b_busy}, {31'd0, m[1].run});
      check("b_done",  {31'd0, b_done}, {31'd0, m[1].done});
      check("b_pass",  {31'd0, b_pass}, {31'd0, m[1].pass});
      check("b_err",   {29'd0, b_err},  m[1].errs);
      check("b_fidx",  {16'd0, b_fidx}, m[1].fidx);
      check("b_fdata", {16'd0, b_fdata}, {16'd0, m[1].fdata});
      check("b_fexp",  {16'd0, b_fexp},  {16'd0, m[1].fexp});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int nw);
    a_start = 1'b1; a_nw = 16'(nw);
    cyc();
    a_start = 1'b0;
  endtask

  task automatic beat_a(input logic [7:0] d);
    a_valid = 1'b1; a_data = d;
    cyc();
    a_valid = 1'b0; a_data = 8'h00;
  endtask

  logic [7:0] good [4] = '{8'h20, 8'h40, 8'h80, 8'h1D};
  bit         gaps [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int j;
    reset = 1'b1;
    a_start = 0; a_nw = 0; a_valid = 0; a_data = 0;
    b_start = 0; b_nw = 0; b_valid = 0; b_data = 0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_pass", {31'd0, a_pass}, 32'd0);
    check("rst_err",  {16'd0, a_err},  32'd0);

    // beat while idle must be ignored
    beat_a(8'hFF);
    check("idle_err", {16'd0, a_err}, 32'd0);

    // 1: clean run
    start_a(4);
    for (int i = 0; i < 4; i++) beat_a(good[i]);
    check("t1_done", {31'd0, a_done}, 32'd1);
    check("t1_pass", {31'd0, a_pass}, 32'd1);
    check("t1_err",  {16'd0, a_err},  32'd0);
    cyc();
    check("t1_done_pulse", {31'd0, a_done}, 32'd0);
    check("t1_pass_held",  {31'd0, a_pass}, 32'd1);

    // 2: beat 2 corrupted
    start_a(4);
    check("t2_pass_clr", {31'd0, a_pass}, 32'd0);
    beat_a(8'h20); beat_a(8'h40); beat_a(8'h81); beat_a(8'h1D);
    check("t2_done",  {31'd0, a_done}, 32'd1);
    check("t2_err",   {16'd0, a_err},  32'd1);
    check("t2_pass",  {31'd0, a_pass}, 32'd0);
    check("t2_fidx",  {16'd0, a_fidx}, 32'd2);
    check("t2_fdata", {24'd0, a_fdata}, 32'h81);
    check("t2_fexp",  {24'd0, a_fexp},  32'h80);

    // 3: valid gaps, garbage on idle cycles, start during CHECK ignored
    start_a(4);
    j = 0;
    for (int i = 0; i < 7; i++) begin
      if (gaps[i]) begin
        beat_a(good[j]);
        j++;
      end else begin
        a_data = 8'hFF;
        if (i == 2) begin a_start = 1'b1; a_nw = 16'd7; end
        cyc();
        a_start = 1'b0; a_data = 8'h00;
        check("t3_busy_gap", {31'd0, a_busy}, 32'd1);
      end
    end
    check("t3_done", {31'd0, a_done}, 32'd1);
    check("t3_pass", {31'd0, a_pass}, 32'd1);

    // 4: two lanes, every beat wrong, 3-bit counter saturates
    b_start = 1'b1; b_nw = 16'd10;
    cyc();
    b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_valid = 1'b1; b_data = expected(2, i) ^ 16'h0101;
      cyc();
    end
    b_valid = 1'b0; b_data = 16'h0000;
    check("t4_done",  {31'd0, b_done}, 32'd1);
    check("t4_err",   {29'd0, b_err},  32'd7);
    check("t4_pass",  {31'd0, b_pass}, 32'd0);
    check("t4_fidx",  {16'd0, b_fidx}, 32'd0);
    check("t4_fexp",  {16'd0, b_fexp},  32'h2120);
    check("t4_fdata", {16'd0, b_fdata}, 32'h2021);

    // 5: empty run, then a 3-beat run
    start_a(0);
    check("t5_done0", {31'd0, a_done}, 32'd1);
    check("t5_pass0", {31'd0, a_pass}, 32'd1);
    check("t5_busy0", {31'd0, a_busy}, 32'd0);
    start_a(3);
    check("t5_busy", {31'd0, a_busy}, 32'd1);
    for (int i = 0; i < 3; i++) beat_a(good[i]);
    check("t5_done", {31'd0, a_done}, 32'd1);
    check("t5_pass", {31'd0, a_pass}, 32'd1);
    check("t5_err",  {16'd0, a_err},  32'd0);

    // 6: reset mid-run, then a fresh run from the seed
    start_a(4);
    beat_a(8'h20); beat_a(8'h99);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_busy", {31'd0, a_busy}, 32'd0);
    check("t6_done", {31'd0, a_done}, 32'd0);
    check("t6_err",  {16'd0, a_err},  32'd0);
    check("t6_fdata", {24'd0, a_fdata}, 32'd0);
    cyc();
    check("t6_nodone", {31'd0, a_done}, 32'd0);
    start_a(4);
    for (int i = 0; i < 4; i++) beat_a(good[i]);
    check("t6_done2", {31'd0, a_done}, 32'd1);
    check("t6_pass2", {31'd0, a_pass}, 32'd1);

    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
